wb_stage: RTL

- Writeback stage of the 5-stage MIPS pipeline.
- Accepts one retiring instruction per handshake from the MEM stage and waits for the data-memory read response on loads.
- Extracts, extends and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR) or selects the ALU result or link address.
- Drives the register-file write port, byte-enabled, that the ID stage's register file consumes, together with the retiring PC.

---
 rtl/wb_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage MIPS pipeline: accepts one retiring
// instruction from MEM, waits for load data, formats it and drives the
// byte-enabled register-file write port with the retiring PC.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        wb_allowin,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_regnum,
    input  logic [3:0]  mem_sel_wb,
    input  logic [4:0]  mem_lubhw,
    input  logic [1:0]  mem_lr_con,
    input  logic [1:0]  mem_addr_low,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] dm_rdata,
    input  logic        dm_rvalid,
    output logic [3:0]  reg_we_wb,
    output logic [4:0]  regnum_wb,
    output logic [31:0] wbdata,
    output logic [31:0] wb_pc,
    output logic        wb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LWAIT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] lat_pc;
    logic [4:0]  lat_regnum;
    logic [3:0]  lat_sel_wb;
    logic [4:0]  lat_lubhw;
    logic [1:0]  lat_lr_con;
    logic [1:0]  lat_addr_low;
    logic [31:0] lat_alu_res;
    logic        accept;

    // Produces {byte enables, write data}; disabled bytes are forced to zero.
    // Source priority ALU > load > link > none; an empty load type acts as LW.
    function automatic logic [35:0] wb_format(
        input logic [3:0]  sel,
        input logic [4:0]  lubhw,
        input logic [1:0]  lr,
        input logic [1:0]  addr,
        input logic [31:0] alu,
        input logic [31:0] pc,
        input logic [31:0] rdata,
        input logic [4:0]  regnum
    );
        logic [3:0]  we;
        logic [31:0] data;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        we     = 4'b1111;
        data   = 32'h0;
        byte_v = rdata[{addr, 3'b000} +: 8];
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        if (sel[0]) begin
            data = alu;
        end else if (sel[1]) begin
            if (lr[0]) begin
                case (addr)
                    2'd0:    begin we = 4'b1000; data = {rdata[7:0],  24'h0}; end
                    2'd1:    begin we = 4'b1100; data = {rdata[15:0], 16'h0}; end
                    2'd2:    begin we = 4'b1110; data = {rdata[23:0], 8'h0};  end
                    default: begin we = 4'b1111; data = rdata;                end
                endcase
            end else if (lr[1]) begin
                case (addr)
                    2'd0:    begin we = 4'b1111; data = rdata;                 end
                    2'd1:    begin we = 4'b0111; data = {8'h0,  rdata[31:8]};  end
                    2'd2:    begin we = 4'b0011; data = {16'h0, rdata[31:16]}; end
                    default: begin we = 4'b0001; data = {24'h0, rdata[31:24]}; end
                endcase
            end else if (lubhw[0]) begin
                data = {{24{byte_v[7]}}, byte_v};
            end else if (lubhw[1]) begin
                data = {24'h0, byte_v};
            end else if (lubhw[2]) begin
                data = {{16{half_v[15]}}, half_v};
            end else if (lubhw[3]) begin
                data = {16'h0, half_v};
            end else if (lubhw[4]) begin
                data = rdata;
            end else begin
                data = rdata;
            end
        end else if (sel[2]) begin
            data = pc + 32'd8;
        end else if (sel[3]) begin
            we = 4'b0000;
        end else begin
            we = 4'b0000;
        end
        if (regnum == 5'd0) begin
            we = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            if (!we[i]) begin
                data[8*i +: 8] = 8'h0;
            end
        end
        return {we, data};
    endfunction

    // Ready whenever no load is outstanding.
    assign wb_allowin = (state == IDLE) || (state == WRITE);
    assign wb_busy    = (state != IDLE);
    assign accept     = mem_valid && wb_allowin;

    // Writeback FSM with registered register-file port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            reg_we_wb    <= 4'b0000;
            regnum_wb    <= 5'd0;
            wbdata       <= 32'h0;
            wb_pc        <= RESET_PC;
            lat_pc       <= 32'h0;
            lat_regnum   <= 5'd0;
            lat_sel_wb   <= 4'b0000;
            lat_lubhw    <= 5'b00000;
            lat_lr_con   <= 2'b00;
            lat_addr_low <= 2'b00;
            lat_alu_res  <= 32'h0;
        end else begin
            reg_we_wb <= 4'b0000;
            case (state)
                IDLE, WRITE: begin
                    if (accept) begin
                        lat_pc       <= mem_pc;
                        lat_regnum   <= mem_regnum;
                        lat_sel_wb   <= mem_sel_wb;
                        lat_lubhw    <= mem_lubhw;
                        lat_lr_con   <= mem_lr_con;
                        lat_addr_low <= mem_addr_low;
                        lat_alu_res  <= mem_alu_res;
                        if (mem_sel_wb[1] && !mem_sel_wb[0]) begin
                            state <= LWAIT;
                        end else begin
                            {reg_we_wb, wbdata} <= wb_format(mem_sel_wb, mem_lubhw,
                                mem_lr_con, mem_addr_low, mem_alu_res, mem_pc,
                                dm_rdata, mem_regnum);
                            regnum_wb <= mem_regnum;
                            wb_pc     <= mem_pc;
                            state     <= WRITE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LWAIT: begin
                    if (dm_rvalid) begin
                        {reg_we_wb, wbdata} <= wb_format(lat_sel_wb, lat_lubhw,
                            lat_lr_con, lat_addr_low, lat_alu_res, lat_pc,
                            dm_rdata, lat_regnum);
                        regnum_wb <= lat_regnum;
                        wb_pc     <= lat_pc;
                        state     <= WRITE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
